// File: rtl/wb_interconnect.sv
// wb_interconnect: single-master, N-slave Wishbone classic shared-bus interconnect
// Registered address decode (lowest matching slave wins), response mux (err > rty > ack),
// error for unmapped addresses. Optional watchdog: define WB_INTERCONNECT_TIMEOUT_EN.
// Ports: clk_i/rst_i (async active-high); m_* master side; s_cyc_o/s_stb_o one-hot per slave;
// s_we_o/s_adr_o/s_sel_o/s_dat_o broadcast; s_dat_i packed slave read data; s_ack_i/s_err_i/s_rty_i.
module wb_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  input  logic                             m_we_i,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic                             m_rty_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  output logic                             s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH/8-1:0]          s_sel_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_err_i,
  input  logic [NUM_SLAVES-1:0]            s_rty_i
);
  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
  state_t state, state_nxt;
  logic [NUM_SLAVES-1:0] hit, sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH/8-1:0] bsel_q;
  logic [DATA_WIDTH-1:0] dat_q, rdat;
  logic we_q, r_ack, r_err, r_rty, any_resp, tmo;
  // Descending scan so the lowest matching index overwrites the others.
  always_comb begin
    hit = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--)
      if ((m_adr_i & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = '0;
        hit[k] = 1'b1;
      end
  end
  always_comb begin
    rdat = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      if (sel_q[k]) rdat = s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
  end
  // Masking with the one-hot selection discards responses from non-selected slaves.
  assign r_ack = |(s_ack_i & sel_q);
  assign r_err = |(s_err_i & sel_q);
  assign r_rty = |(s_rty_i & sel_q);
  assign any_resp = r_ack | r_err | r_rty;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) wd_cnt <= '0;
    else wd_cnt <= (state == ACTIVE) ? wd_cnt + 1'b1 : '0;
  // Fires in the last of TIMEOUT_CYCLES active cycles, so the error lands TIMEOUT_CYCLES after entry.
  assign tmo = (state == ACTIVE) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_cyc_i && m_stb_i) state_nxt = |hit ? ACTIVE : RESP;
      ACTIVE:  state_nxt = !m_cyc_i ? IDLE : (any_resp || tmo) ? RESP : ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state   <= IDLE;
      sel_q   <= '0;
      adr_q   <= '0;
      bsel_q  <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      if (state == IDLE && m_cyc_i && m_stb_i) begin
        sel_q   <= hit;
        adr_q   <= m_adr_i;
        bsel_q  <= m_sel_i;
        dat_q   <= m_dat_i;
        we_q    <= m_we_i;
        m_err_o <= ~|hit;
      end
      if (state == ACTIVE && state_nxt == RESP) begin
        m_err_o <= r_err | ~any_resp;
        m_rty_o <= ~r_err & r_rty;
        m_ack_o <= ~r_err & ~r_rty & r_ack;
        m_dat_o <= (~we_q & ~r_err & ~r_rty & r_ack) ? rdat : '0;
      end
    end
  assign s_cyc_o = (state == ACTIVE) ? sel_q : '0;
  assign s_stb_o = (state == ACTIVE) ? sel_q : '0;
  assign s_we_o  = we_q;
  assign s_adr_o = adr_q;
  assign s_sel_o = bsel_q;
  assign s_dat_o = dat_q;
endmodule

// File: tb/tb_wb_interconnect.sv
// tb_wb_interconnect: timeline-model self-checking bench for wb_interconnect
module tb_wb_interconnect;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
  logic [31:0] m_adr_i = '0, m_dat_i = '0;
  logic [3:0] m_sel_i = '0;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o;
  logic m_ack_o, m_err_o, m_rty_o, s_we_o;
  logic [1:0] s_cyc_o, s_stb_o;
  logic [3:0] s_sel_o;
  logic [63:0] s_dat_i = {2{32'hBAD0_BAD0}};
  logic [1:0] s_ack_i = '0, s_err_i = '0, s_rty_i = '0;

  wb_interconnect #(
    .NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_BASE({32'h2000_0000, 32'h1000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0, ncmp = 0, nerr = 0;
  bit run = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected timeline, keyed by cycle number; absent keys mean "all quiet".
  logic [1:0]  e_stb [int];
  logic [2:0]  e_rsp [int];
  logic [31:0] e_dat [int], e_adr [int], e_wd [int];
  logic [3:0]  e_sel [int];
  logic        e_we  [int];
  logic [1:0]  obs_stb [int];
  logic [2:0]  obs_rsp [int];
  logic [31:0] obs_dat [int], obs_wd [int];
  logic [3:0]  obs_sel [int];

  localparam logic [31:0] BASE [2] = '{32'h1000_0000, 32'h2000_0000};
  localparam logic [31:0] MASK [2] = '{32'hF000_0000, 32'hF000_0000};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 2; k++) if ((a & MASK[k]) == BASE[k]) return k;
    return -1;
  endfunction

  // Response code {ack,err,rty}: error beats retry beats ack.
  function automatic logic [2:0] resolve(input logic [2:0] r);
    return r[1] ? 3'b010 : r[0] ? 3'b001 : r[2] ? 3'b100 : 3'b000;
  endfunction

  always @(negedge clk_i) begin
    logic [1:0] es;
    if (run && !rst_i) begin
      es = e_stb.exists(cyc) ? e_stb[cyc] : 2'b00;
      chk("s_stb_o", s_stb_o, es);
      chk("s_cyc_o", s_cyc_o, es);
      chk("m_resp{ack,err,rty}", {m_ack_o, m_err_o, m_rty_o}, e_rsp.exists(cyc) ? e_rsp[cyc] : 3'b000);
      chk("m_dat_o", m_dat_o, e_dat.exists(cyc) ? e_dat[cyc] : 32'h0);
      if (es != 2'b00) begin
        chk("s_adr_o", s_adr_o, e_adr[cyc]);
        chk("s_sel_o", s_sel_o, e_sel[cyc]);
        chk("s_dat_o", s_dat_o, e_wd[cyc]);
        chk("s_we_o", s_we_o, e_we[cyc]);
      end
      obs_stb[cyc] = s_stb_o;
      obs_rsp[cyc] = {m_ack_o, m_err_o, m_rty_o};
      obs_dat[cyc] = m_dat_o;
      obs_sel[cyc] = s_sel_o;
      obs_wd[cyc]  = s_dat_o;
    end
  end

  task automatic clear_slaves();
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    s_dat_i = {2{32'hBAD0_BAD0}};
  endtask

  task automatic start_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, output int c0);
    @(posedge clk_i); #1;
    c0 = cyc;
    m_cyc_i = 1; m_stb_i = 1; m_we_i = we; m_adr_i = adr; m_sel_i = sel; m_dat_i = wd;
  endtask

  task automatic expect_active(input int c, input int t, input logic [31:0] adr, input logic we,
                               input logic [3:0] sel, input logic [31:0] wd);
    e_stb[c] = 2'b01 << t; e_adr[c] = adr; e_we[c] = we; e_sel[c] = sel; e_wd[c] = wd;
  endtask

  // Slave responds d cycles after its strobe first appears; stray makes the other slave ack early.
  // Returns in the response cycle with the master already released.
  task automatic txn(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] wd,
                     input int d, input logic [2:0] rsp, input logic [31:0] rd, input bit stray,
                     output int c0);
    int t;
    logic [2:0] res;
    t = decode(adr);
    start_req(adr, we, sel, wd, c0);
    if (t < 0) begin
      e_rsp[c0+1] = 3'b010;
      @(posedge clk_i); #1;
      m_cyc_i = 0; m_stb_i = 0;
    end else begin
      res = resolve(rsp);
      for (int i = 1; i <= d + 1; i++) expect_active(c0 + i, t, adr, we, sel, wd);
      e_rsp[c0+2+d] = res;
      e_dat[c0+2+d] = (!we && res == 3'b100) ? rd : 32'h0;
      for (int i = 1; i <= d + 1; i++) begin
        @(posedge clk_i); #1;
        clear_slaves();
        if (stray && i == 1) s_ack_i[1-t] = 1'b1;
        if (i == d + 1) begin
          {s_ack_i[t], s_err_i[t], s_rty_i[t]} = rsp;
          s_dat_i[t*32 +: 32] = rd;
        end
      end
      @(posedge clk_i); #1;
      clear_slaves();
      m_cyc_i = 0; m_stb_i = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    #1 rst_i = 1;
    repeat (2) @(posedge clk_i);
    #2;
    chk("reset s_stb_o/s_cyc_o", {s_stb_o, s_cyc_o}, 4'b0);
    chk("reset m_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b0);
    chk("reset m_dat_o", m_dat_o, 32'h0);
    chk("reset s_adr/s_dat", {s_adr_o, s_dat_o}, 64'h0);
    chk("reset s_sel/s_we", {s_sel_o, s_we_o}, 5'h0);
    @(posedge clk_i); #1 rst_i = 0;
    run = 1;

    txn(32'h1000_0004, 0, 4'hF, 32'h0, 0, 3'b100, 32'hDEAD_BEEF, 0, c0);
    settle();
    chk("t1 stb cyc1", obs_stb[c0+1], 2'b01);
    chk("t1 ack cyc2", obs_rsp[c0+2], 3'b100);
    chk("t1 dat cyc2", obs_dat[c0+2], 32'hDEAD_BEEF);
    chk("t1 quiet cyc3", {obs_rsp[c0+3], obs_dat[c0+3]}, 35'h0);

    txn(32'h2000_0000, 1, 4'b0011, 32'h0000_1234, 0, 3'b100, 32'hFFFF_FFFF, 0, c0);
    settle();
    chk("t2 stb", obs_stb[c0+1], 2'b10);
    chk("t2 sel", obs_sel[c0+1], 4'b0011);
    chk("t2 wdat", obs_wd[c0+1], 32'h0000_1234);
    chk("t2 ack no data", {obs_rsp[c0+2], obs_dat[c0+2]}, {3'b100, 32'h0});

    txn(32'h3000_0000, 0, 4'hF, 32'h0, 0, 3'b000, 32'h0, 0, c0);
    settle();
    chk("t3 no stb", obs_stb[c0+1], 2'b00);
    chk("t3 err cyc1", obs_rsp[c0+1], 3'b010);
    chk("t3 err once", obs_rsp[c0+2], 3'b000);

    txn(32'h1000_0008, 0, 4'hF, 32'h0, 0, 3'b110, 32'h5555_AAAA, 0, c0);
    settle();
    chk("t4 err beats ack", {obs_rsp[c0+2], obs_dat[c0+2]}, {3'b010, 32'h0});

    txn(32'h1000_000C, 0, 4'hF, 32'h0, 2, 3'b100, 32'h0BAD_F00D, 1, c0);
    settle();
    chk("t5 stray ignored", {obs_stb[c0+2], obs_rsp[c0+2]}, {2'b01, 3'b000});
    chk("t5 real ack", obs_dat[c0+4], 32'h0BAD_F00D);

    txn(32'h2000_0010, 0, 4'hF, 32'h0, 1, 3'b001, 32'h1111_2222, 0, c0);
    settle();
    chk("t6 rty", obs_rsp[c0+3], 3'b001);
    txn(32'h1000_0020, 1, 4'b1100, 32'hCAFE_0000, 3, 3'b010, 32'h0, 0, c0);
    txn(32'h2000_0004, 0, 4'b0001, 32'h0, 0, 3'b101, 32'h7777_7777, 0, c0);
    settle();
    chk("t8 rty beats ack", obs_rsp[c0+2], 3'b001);
    txn(32'h1000_0000, 1, 4'hF, 32'h89AB_CDEF, 0, 3'b100, 32'hFFFF_FFFF, 0, c0);

`ifdef WB_INTERCONNECT_TIMEOUT_EN
    start_req(32'h2000_0008, 0, 4'hF, 32'h0, c0);
    for (int i = 1; i <= 8; i++) expect_active(c0 + i, 1, 32'h2000_0008, 0, 4'hF, 32'h0);
    e_rsp[c0+9] = 3'b010;
    repeat (9) @(posedge clk_i);
    #1 m_cyc_i = 0; m_stb_i = 0;
    settle();
    chk("timeout err", {obs_stb[c0+9], obs_rsp[c0+9]}, {2'b00, 3'b010});
`else
    start_req(32'h1000_0010, 0, 4'hF, 32'h0, c0);
    for (int i = 1; i <= 101; i++) expect_active(c0 + i, 0, 32'h1000_0010, 0, 4'hF, 32'h0);
    repeat (100) @(posedge clk_i);
    settle();
    chk("pending at 100", {obs_stb[c0+100], obs_rsp[c0+100]}, {2'b01, 3'b000});
    @(posedge clk_i); #1 m_cyc_i = 0; m_stb_i = 0;
    @(posedge clk_i); #1 s_ack_i[0] = 1'b1;
    @(posedge clk_i); #1 clear_slaves();
    settle();
    chk("abort late ack", {obs_stb[c0+102], obs_rsp[c0+103]}, {2'b00, 3'b000});
`endif
    repeat (2) @(posedge clk_i);

    start_req(32'h1000_0040, 1, 4'hF, 32'h4242_4242, c0);
    expect_active(c0 + 1, 0, 32'h1000_0040, 1, 4'hF, 32'h4242_4242);
    @(negedge clk_i); #1;
    rst_i = 1;
    #1;
    chk("async rst s_stb/s_cyc", {s_stb_o, s_cyc_o}, 4'b0);
    chk("async rst m_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b0);
    chk("async rst s_adr/s_dat", {s_adr_o, s_dat_o}, 64'h0);
    chk("async rst s_sel/s_we", {s_sel_o, s_we_o}, 5'h0);
    m_cyc_i = 0; m_stb_i = 0;
    e_stb.delete(); e_rsp.delete(); e_dat.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    txn(32'h2000_0020, 0, 4'hF, 32'h0, 1, 3'b100, 32'h1357_9BDF, 0, c0);
    settle();
    chk("post-reset read", {obs_rsp[c0+3], obs_dat[c0+3]}, {3'b100, 32'h1357_9BDF});
    repeat (3) @(posedge clk_i);
    settle();
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
- Parametrised single-master, N-slave Wishbone classic shared-bus interconnect; sits between `cpu` and the SoC peripherals (memory, GPIO, UART, ...) in `top`.
- Replaces the fixed single-slave hookup with a registered address decoder and a response multiplexer.
- Returns an error for unmapped addresses and, optionally, for hung slaves via a watchdog.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; SEL width = DATA_WIDTH/8
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slave k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- SLAVE_MASK, {NUM_SLAVES{32'h0}}, packed NUM_SLAVES*ADDR_WIDTH masks; slave k matches when (adr & MASK_k) == BASE_k
- TIMEOUT_CYCLES, 255, watchdog limit in clk_i cycles (used only with WB_INTERCONNECT_TIMEOUT_EN)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- m_cyc_i  in  1  master cycle
- m_stb_i  in  1  master strobe
- m_we_i  in  1  master write enable
- m_adr_i  in  ADDR_WIDTH  master address
- m_sel_i  in  DATA_WIDTH/8  master byte select
- m_dat_i  in  DATA_WIDTH  master write data
- m_dat_o  out  DATA_WIDTH  read data to master
- m_ack_o  out  1  acknowledge to master
- m_err_o  out  1  error to master
- m_rty_o  out  1  retry to master
- s_cyc_o  out  NUM_SLAVES  per-slave cycle
- s_stb_o  out  NUM_SLAVES  per-slave strobe
- s_we_o  out  1  broadcast write enable
- s_adr_o  out  ADDR_WIDTH  broadcast address
- s_sel_o  out  DATA_WIDTH/8  broadcast byte select
- s_dat_o  out  DATA_WIDTH  broadcast write data
- s_dat_i  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- s_ack_i  in  NUM_SLAVES  slave acknowledges
- s_err_i  in  NUM_SLAVES  slave errors
- s_rty_i  in  NUM_SLAVES  slave retries

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; latched address, data, select and slave index cleared; watchdog counter 0.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE:
  - Waits for m_cyc_i & m_stb_i.
  - Latches adr, sel, dat, we and a one-hot match vector. Lowest matching index wins on overlap.
  - Any match -> ACTIVE. No match -> RESP with err=1.
- ACTIVE:
  - s_cyc_o[k] and s_stb_o[k] asserted for the selected k only; all other bits 0.
  - s_adr_o, s_sel_o, s_dat_o and s_we_o are driven from the latches.
  - On s_ack_i[k], s_err_i[k] or s_rty_i[k]: latch response and s_dat_i slice k -> RESP.
  - Simultaneous responses resolve with priority err > rty > ack.
  - Responses from non-selected slaves are ignored.
- RESP:
  - Exactly one of m_ack_o, m_err_o, m_rty_o is high for one cycle.
  - m_dat_o holds the latched read data for a read ack; otherwise 0.
  - s_stb_o and s_cyc_o are 0.
  - Next state IDLE.
- Latency: request seen at cycle 0 -> slave strobe at cycle 1 -> if the slave acks in cycle 1, m_ack_o is asserted in cycle 2. Minimum 2 cycles; one transaction in flight.
- Back-to-back: a master strobe present in the IDLE cycle immediately after RESP starts a new transaction.
- Master abort: m_cyc_i=0 while ACTIVE -> IDLE next cycle. Slave strobes drop, no response is generated, and a late slave ack is ignored.
- m_dat_o, m_ack_o, m_err_o and m_rty_o are registered outputs. s_* outputs are registered, or decoded purely from state and latches.

Optional Feature:
- Macro: WB_INTERCONNECT_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ACTIVE and increments each ACTIVE cycle.
  - If the count reaches TIMEOUT_CYCLES with no slave response, go to RESP with m_err_o=1 and drop the slave strobe.
  - A slave response in the same cycle as the timeout wins.
- Undefined: no counter; ACTIVE waits indefinitely for the slave.

Test Plan:
- NUM_SLAVES=2, BASE0=0x1000_0000, MASK0=0xF000_0000; read 0x1000_0004 with slave0 acking in cycle 1 with 0xDEADBEEF -> s_stb_o=2'b01 in cycle 1; m_ack_o=1 and m_dat_o=0xDEADBEEF in cycle 2 only.
- Write 0x2000_0000 (BASE1=0x2000_0000), sel=4'b0011, dat=0x0000_1234 -> s_stb_o=2'b10; s_sel_o=4'b0011 and s_dat_o=0x1234 while ACTIVE; one m_ack_o pulse.
- Access to unmapped 0x3000_0000 -> no s_stb_o bit ever set; m_err_o=1 for exactly one cycle, 1 cycle after the request.
- Slave0 asserts ack and err together -> m_err_o=1, m_ack_o=0. Separate case: slave1 acks while slave0 is selected -> ignored, FSM stays in ACTIVE.
- With WB_INTERCONNECT_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never responds -> m_err_o pulses 8 cycles after entering ACTIVE, then IDLE. Without the macro the transaction is still pending at cycle 100.
- Assert rst_i mid-ACTIVE -> all outputs 0 immediately (asynchronously); after release, a new read completes normally.
